muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Parametrised iterative multiply/divide unit for the EX stage of the pipelined CPU.
//   Executes MULT/MULTU/DIV/DIVU over several cycles and holds results in internal HI/LO
//   registers. Raises stall_o so the hazard detection unit can freeze PC, IF_ID and ID_EX.
//   Adds multi-cycle execution and pipeline cancellation, which the single-cycle ALU path lacks.
// PARAMETERS
//   WIDTH   32  operand width in bits; HI and LO are each WIDTH bits wide.
//   UNROLL  1   result bits processed per iteration; must divide WIDTH evenly (1, 2, 4, ...).
// PORTS
//   clk_i      in   1      clock, rising edge
//   rst_i      in   1      asynchronous, active-low reset
//   start_i    in   1      issue request; op_i/data1_i/data2_i valid in the same cycle
//   op_i       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   data1_i    in   WIDTH  rs operand (multiplicand / dividend)
//   data2_i    in   WIDTH  rt operand (multiplier / divisor)
//   read_i     in   1      MFHI/MFLO present in ID stage
//   flush_i    in   1      cancel the in-flight operation (branch/jump flush)
//   busy_o     out  1      operation in progress
//   done_o     out  1      one-cycle pulse when HI/LO have just been updated
//   stall_o    out  1      busy_o & (start_i | read_i); combinational
//   hi_o       out  WIDTH  HI register (product upper half / remainder)
//   lo_o       out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//   Reset (rst_i=0, async): state IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0; stall_o follows.
//   FSM states: IDLE -> RUN -> FIX -> IDLE.
//   - IDLE: on start_i=1 and flush_i=0, latch the operands and go to RUN.
//     * Signed ops latch |operands| and record the result sign(s).
//     * Unsigned ops latch operands as-is.
//     * Iteration counter is set to 0; busy_o=1 from the next cycle.
//   - RUN: one shift-add (multiply) or restoring-subtract (divide) step of UNROLL bits per cycle.
//     After N = WIDTH/UNROLL cycles, go to FIX.
//   - FIX: apply two's-complement sign correction, write hi_o/lo_o, pulse done_o=1,
//     clear busy_o on the same edge, and return to IDLE.
//   Latency: start sampled at edge 0 -> hi_o/lo_o and done_o update at edge N+1.
//     busy_o is high for N+1 cycles.
//   Arithmetic:
//     * MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
//     * DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
//   Boundary cases:
//     * Divide by zero (any DIV): hi = dividend, lo = all ones; takes normal latency, no exception.
//     * Signed MIN / -1: lo = MIN, hi = 0.
//     * start_i while busy_o=1: ignored (operands not latched); stall_o=1 holds the issuing
//       instruction in ID.
//     * read_i while busy_o=1: stall_o=1. read_i in the done_o cycle sees the new hi_o/lo_o
//       and does not stall.
//     * flush_i=1 in RUN or FIX: return to IDLE next edge; hi_o/lo_o keep their previous values;
//       no done_o pulse.
//     * flush_i=1 with start_i=1 in IDLE: start is suppressed.
//     * Reset asserted mid-operation: immediate return to reset values; the operation is lost.
//   hi_o/lo_o change only at the FIX edge or on reset.
// TESTING (WIDTH=32, UNROLL=1 unless noted)
//   1. MULT 7, 0xFFFFFFFD -> done_o at edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy_o high 33 cycles.
//   2. MULTU 0xFFFFFFFF, 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//   3. DIV 0xFFFFFFF9(-7), 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      DIVU 7, 0 -> hi=7, lo=0xFFFFFFFF.
//   4. DIV 0x80000000, 0xFFFFFFFF -> lo=0x80000000, hi=0.
//      DIVU 0x80000000, 0xFFFFFFFF -> lo=0, hi=0x80000000.
//   5. Second start_i at cycle 5 -> ignored, stall_o=1, first result unchanged.
//      flush_i at cycle 10 of a new op -> idle at 11, hi/lo retain prior values, no done_o.
//   6. rst_i low at cycle 12 -> all outputs 0 immediately.
//      UNROLL=4: MULTU 0x12345678, 0x10 -> done_o at edge 9, hi=0x1, lo=0x23456780.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO registers for the EX stage
//
// Purpose: executes MULT/MULTU/DIV/DIVU over WIDTH/UNROLL + 1 cycles using shift-add
// multiplication and restoring division on operand magnitudes, then applies sign
// correction and writes HI/LO. Supports pipeline flush and raises a stall request.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-low reset
//   start_i  in   issue request (op_i/data1_i/data2_i valid in the same cycle)
//   op_i     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   data1_i  in   multiplicand / dividend
//   data2_i  in   multiplier / divisor
//   read_i   in   MFHI/MFLO present in ID stage
//   flush_i  in   cancel the in-flight operation
//   busy_o   out  operation in progress
//   done_o   out  one-cycle pulse after HI/LO update
//   stall_o  out  busy_o & (start_i | read_i)
//   hi_o     out  product upper half / remainder
//   lo_o     out  product lower half / quotient

module muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             read_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_busy;

  // Shared working register: {partial product upper, multiplier} for multiply,
  // {partial remainder, dividend/quotient} for divide.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opd;   // multiplicand magnitude or divisor magnitude
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q; // negate product / quotient
  logic               r_neg_r; // negate remainder
  logic               r_div0;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_start_ok;
  logic               w_signed;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_sum;
  logic               w_bit;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;

  assign w_start_ok = start_i & ~flush_i;
  assign w_signed   = ~op_i[0];
  // Two's-complement negation of MIN yields MIN, which is the correct unsigned magnitude.
  assign w_mag1 = (w_signed & data1_i[WIDTH-1]) ? -data1_i : data1_i;
  assign w_mag2 = (w_signed & data2_i[WIDTH-1]) ? -data2_i : data2_i;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and busy indication
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_next = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (flush_i)             w_state_next = S_IDLE;
        else if (r_cnt == LAST)  w_state_next = S_FIX;
      end
      S_FIX: begin
        w_busy       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // UNROLL iterations of shift-add or restoring subtract
  always_comb begin
    w_acc_step = r_acc;
    w_rem_sh   = '0;
    w_sum      = '0;
    w_bit      = 1'b0;
    for (int k = 0; k < UNROLL; k++) begin
      if (r_is_div) begin
        w_rem_sh = w_acc_step[2*WIDTH-1:WIDTH-1];
        if (w_rem_sh >= {1'b0, r_opd}) begin
          w_rem_sh = w_rem_sh - {1'b0, r_opd};
          w_bit    = 1'b1;
        end else begin
          w_bit    = 1'b0;
        end
        // Remainder always fits WIDTH bits after the compare/subtract.
        w_acc_step = {w_rem_sh[WIDTH-1:0], w_acc_step[WIDTH-2:0], w_bit};
      end else begin
        w_sum = {1'b0, w_acc_step[2*WIDTH-1:WIDTH]}
              + (w_acc_step[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
        w_acc_step = {w_sum, w_acc_step[WIDTH-1:1]};
      end
    end
  end

  // Sign correction of the finished magnitudes
  always_comb begin
    w_prod_fix = r_neg_q ? -r_acc : r_acc;
    if (r_is_div) begin
      // Divide by zero leaves the dividend magnitude in the remainder; restoring its
      // sign gives back the dividend. The quotient must stay all ones regardless of sign.
      w_lo_fix = r_div0  ? {WIDTH{1'b1}}
               : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
      w_hi_fix = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end else begin
      w_hi_fix = w_prod_fix[2*WIDTH-1:WIDTH];
      w_lo_fix = w_prod_fix[WIDTH-1:0];
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_acc    <= '0;
      r_opd    <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_is_div <= op_i[1];
            r_cnt    <= '0;
            r_neg_q  <= w_signed & (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]);
            r_neg_r  <= w_signed & data1_i[WIDTH-1];
            r_div0   <= (data2_i == '0);
            if (op_i[1]) begin
              r_acc <= {{WIDTH{1'b0}}, w_mag1};
              r_opd <= w_mag2;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_mag2};
              r_opd <= w_mag1;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (!flush_i) begin
            r_hi   <= w_hi_fix;
            r_lo   <= w_lo_fix;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o  = w_busy;
  assign done_o  = r_done;
  assign stall_o = w_busy & (start_i | read_i);
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (UNROLL 1 and 4 side by side)

module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        read  = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op    = 2'd0;
  logic [31:0] d1    = '0;
  logic [31:0] d2    = '0;

  logic        busy  [2];
  logic        done  [2];
  logic        stall [2];
  logic [31:0] hi    [2];
  logic [31:0] lo    [2];

  muldiv_unit #(.WIDTH(32), .UNROLL(1)) u0 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .op_i(op), .data1_i(d1), .data2_i(d2),
    .read_i(read), .flush_i(flush), .busy_o(busy[0]), .done_o(done[0]), .stall_o(stall[0]),
    .hi_o(hi[0]), .lo_o(lo[0])
  );

  muldiv_unit #(.WIDTH(32), .UNROLL(4)) u1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .op_i(op), .data1_i(d1), .data2_i(d2),
    .read_i(read), .flush_i(flush), .busy_o(busy[1]), .done_o(done[1]), .stall_o(stall[1]),
    .hi_o(hi[1]), .lo_o(lo[1])
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference arithmetic straight from the instruction definitions.
  function automatic logic [63:0] calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (o)
      2'd0: p = 64'(longint'(sa) * longint'(sb));
      2'd1: p = {32'h0, a} * {32'h0, b};
      2'd2: begin
        if (b == 32'h0)                                  p = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
        else                                             p = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else            p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Transaction-level model: remaining busy cycles per instance, pending result.
  int          nn    [2] = '{33, 9};
  int          m_cnt [2] = '{0, 0};
  logic        m_done[2] = '{1'b0, 1'b0};
  logic [31:0] m_hi  [2] = '{32'h0, 32'h0};
  logic [31:0] m_lo  [2] = '{32'h0, 32'h0};
  logic [63:0] m_pend[2] = '{64'h0, 64'h0};

  always @(posedge clk or negedge rst_n) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_cnt[u]  = 0;
        m_done[u] = 1'b0;
        m_hi[u]   = '0;
        m_lo[u]   = '0;
      end else if (m_cnt[u] != 0) begin
        m_done[u] = 1'b0;
        if (flush) begin
          m_cnt[u] = 0;
        end else begin
          m_cnt[u]--;
          if (m_cnt[u] == 0) begin
            m_hi[u]   = m_pend[u][63:32];
            m_lo[u]   = m_pend[u][31:0];
            m_done[u] = 1'b1;
          end
        end
      end else begin
        m_done[u] = 1'b0;
        if (start && !flush) begin
          m_pend[u] = calc(op, d1, d2);
          m_cnt[u]  = nn[u];
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always begin
    @(posedge clk);
    #2;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("cycle u%0d t=%0t {busy,done,stall,hi,lo}", u, $time),
            {busy[u], done[u], stall[u], hi[u], lo[u]},
            {m_cnt[u] != 0, m_done[u], (m_cnt[u] != 0) & (start | read), m_hi[u], m_lo[u]});
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int t0, output int t1, output int bc);
    @(negedge clk);
    op = o; d1 = a; d2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = busy[0] ? 1 : 0;
    t0 = -1;
    t1 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #2;
      if (done[1] && t1 < 0) t1 = i;
      if (busy[0]) bc++;
      if (done[0]) begin
        t0 = i;
        break;
      end
    end
  endtask

  task automatic wait_done0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (done[0]) break;
    end
  endtask

  int t0, t1, bc, ndone;

  initial begin
    repeat (2) @(negedge clk);
    check("reset u0", {busy[0], done[0], stall[0], hi[0], lo[0]}, '0);
    check("reset u1", {busy[1], done[1], stall[1], hi[1], lo[1]}, '0);
    rst_n = 1'b1;

    // MULT 7 * -3
    run_op(2'd0, 32'd7, 32'hFFFFFFFD, t0, t1, bc);
    check("mult latency u0", t0, 33);
    check("mult latency u1", t1, 9);
    check("mult busy cycles", bc, 33);
    check("mult u0", {hi[0], lo[0]}, {32'hFFFFFFFF, 32'hFFFFFFEB});
    check("mult u1", {hi[1], lo[1]}, {32'hFFFFFFFF, 32'hFFFFFFEB});
    @(negedge clk);
    read = 1'b1;
    #1;
    check("read in done cycle {done,stall}", {done[0], stall[0]}, 2'b10);
    read = 1'b0;

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, t0, t1, bc);
    check("multu max", {hi[0], lo[0]}, {32'hFFFFFFFE, 32'h00000001});
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, t0, t1, bc);
    check("div -7/2", {hi[0], lo[0]}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(2'd3, 32'd7, 32'd0, t0, t1, bc);
    check("divu 7/0", {hi[0], lo[0]}, {32'h00000007, 32'hFFFFFFFF});
    check("divu 7/0 latency", t0, 33);
    run_op(2'd2, 32'hFFFFFFF9, 32'd0, t0, t1, bc);
    check("div -7/0", {hi[0], lo[0]}, {32'hFFFFFFF9, 32'hFFFFFFFF});
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, t0, t1, bc);
    check("div min/-1", {hi[0], lo[0]}, {32'h00000000, 32'h80000000});
    run_op(2'd3, 32'h80000000, 32'hFFFFFFFF, t0, t1, bc);
    check("divu 8000_0000/ffff_ffff", {hi[0], lo[0]}, {32'h80000000, 32'h00000000});
    run_op(2'd1, 32'h12345678, 32'h10, t0, t1, bc);
    check("unroll4 latency", t1, 9);
    check("unroll4 multu", {hi[1], lo[1]}, {32'h00000001, 32'h23456780});

    // Second start while busy is ignored and stalls
    @(negedge clk);
    op = 2'd1; d1 = 32'd3; d2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = 2'd2; d1 = 32'd100; d2 = 32'd7; start = 1'b1;
    #1;
    check("start while busy stall", stall[0], 1'b1);
    @(negedge clk);
    start = 1'b0; read = 1'b1;
    #1;
    check("read while busy stall", stall[0], 1'b1);
    read = 1'b0;
    wait_done0();
    check("ignored start result", {hi[0], lo[0]}, {32'h0, 32'd15});

    // Flush at cycle 10 of a new operation
    @(negedge clk);
    op = 2'd1; d1 = 32'h1234; d2 = 32'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy u0", busy[0], 1'b0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (done[0]) ndone++;
    end
    check("flush no done", ndone, 0);
    check("flush keeps hi/lo", {hi[0], lo[0]}, {32'h0, 32'd15});
    check("u1 finished before flush", {hi[1], lo[1]}, {32'h0, 32'h12340});

    // Flush together with start in idle
    @(negedge clk);
    op = 2'd1; d1 = 32'd2; d2 = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start suppressed by flush", {busy[0], busy[1]}, 2'b00);

    // Reset mid-operation
    @(negedge clk);
    op = 2'd3; d1 = 32'd1000; d2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset u0", {busy[0], done[0], stall[0], hi[0], lo[0]}, '0);
    check("async reset u1", {busy[1], done[1], stall[1], hi[1], lo[1]}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, t0, t1, bc);
    check("mult -1*-1 after reset", {hi[0], lo[0]}, {32'h0, 32'h1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
